reg_file_loader: RTL and testbench
==================================

// Module: reg_file_loader
// PURPOSE
//  Write-side counterpart to the register file read path: accepts a byte stream
//  (decoded AVR serial bytes) and turns 5-byte frames into single-cycle register
//  file writes on wr_en/wr_reg_index/wr_reg_data. Sits between the serial byte
//  receiver and reg_file in mojo_top; lets the host preload registers for
//  read-back on reg_data_1.
// PARAMETERS
//  REGISTER_WIDTH   32         data width of one register (frame carries 4 bytes)
//  REG_INDEX_WIDTH  5          register index width
//  SYNC_TAG         3'b101     required value of header bits [7:5]
//  TIMEOUT_CYCLES   1000000    max idle cycles between bytes of a frame (20 ms @ 50 MHz)
// PORTS
//  clk           in   1    system clock (50 MHz)
//  rst           in   1    asynchronous, active-high reset
//  rx_data       in   8    incoming byte
//  rx_valid      in   1    rx_data valid
//  rx_ready      out  1    loader can accept a byte; transfer = rx_valid & rx_ready
//  wr_en         out  1    register file write strobe, one-cycle pulse
//  wr_reg_index  out  5    register index to write
//  wr_reg_data   out  32   data to write
//  busy          out  1    high while a frame is in progress (state != IDLE)
//  frame_err     out  1    one-cycle pulse: bad header or inter-byte timeout
//  wr_count      out  8    number of committed writes, wraps 255 -> 0
// BEHAVIOUR
//  Frame: header byte {SYNC_TAG, index[4:0]}, then 4 data bytes, little-endian
//   (first data byte -> wr_reg_data[7:0], last -> [31:24]).
//  FSM states: IDLE, DATA, WRITE. Reset -> IDLE.
//  Reset values: wr_en 0, wr_reg_index 0, wr_reg_data 0, frame_err 0,
//   wr_count 0, busy 0, rx_ready 1 (IDLE). Reset mid-frame discards partial frame.
//  IDLE: rx_ready=1. Accepted byte with [7:5]==SYNC_TAG -> latch index, byte_cnt=0,
//   -> DATA. Accepted byte with wrong tag -> frame_err pulse next cycle, stay IDLE.
//  DATA: rx_ready=1. Each accepted byte shifts into data lane byte_cnt; byte_cnt
//   increments. Acceptance of 4th byte (byte_cnt==3) -> WRITE.
//   Timeout counter clears on every accepted byte; if it reaches TIMEOUT_CYCLES-1
//   with no byte accepted: frame_err pulse, discard frame, -> IDLE.
//  WRITE: exactly one cycle; rx_ready=0; -> IDLE.
//   wr_en=1 in this cycle with wr_reg_index/wr_reg_data stable and valid,
//   unless index==0: x0 is hardwired zero, so wr_en stays 0 and wr_count is not
//   incremented (not an error). Otherwise wr_count increments.
//  Latency: 4th data byte accepted in cycle N -> wr_en high in cycle N+1;
//   next header acceptable in cycle N+2. Peak rate: 1 write per 6 cycles.
//  wr_reg_index/wr_reg_data hold last frame value after write (only wr_en pulses).
//  rx_valid with rx_ready=0 is not consumed; upstream must hold the byte.
//  Header tag check only in IDLE; data bytes are never tag-checked.
//  wr_count wraps 8'hFF -> 8'h00 silently.
// STRUCTURE
//  Shared header reg_file_defs.vh: REGISTER_WIDTH, REG_INDEX_WIDTH, SYNC_TAG,
//   state encodings (IDLE=2'd0, DATA=2'd1, WRITE=2'd2). reg_file uses same header.
//  Single module; timeout counter (20-bit) inline, no sub-module.
// TESTING
//  1 Frame A3 78 56 34 12 back-to-back -> one wr_en pulse, index 3, data
//    32'h12345678, cycle after last byte; wr_count=1; reg_data_1 reads it back.
//  2 Header 43 (tag 010) -> frame_err pulse, no wr_en; following frame A1 01 00 00 00
//    -> writes 32'h1 to x1.
//  3 Frame A0 FF FF FF FF -> no wr_en, no frame_err, wr_count unchanged.
//  4 A5 11 22 then idle TIMEOUT_CYCLES -> frame_err pulse, busy drops; next frame
//    A5 .. written correctly with no stale bytes.
//  5 rx_valid held high continuously across two frames -> rx_ready low exactly
//    the WRITE cycle, no byte lost, two writes, wr_count=2.
//  6 rst asserted after header + 2 data bytes -> all outputs to reset values
//    immediately; no wr_en; fresh frame after release writes correctly.

Source files
------------

// File: rtl/reg_file_loader_pkg.sv
// Shared definitions for the register-file write loader: widths, the header
// sync tag, FSM state encoding and the write-command payload.
package reg_file_loader_pkg;

  localparam int unsigned REGISTER_WIDTH     = 32;
  localparam int unsigned REG_INDEX_WIDTH    = 5;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned DATA_BYTES         = REGISTER_WIDTH / BYTE_W;
  localparam int unsigned BYTE_CNT_W         = 2;
  localparam int unsigned WR_COUNT_W         = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

  localparam logic [2:0] SYNC_TAG = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // One register-file write: target index and data word.
  typedef struct packed {
    logic [REG_INDEX_WIDTH-1:0] index;
    logic [REGISTER_WIDTH-1:0]  data;
  } wr_cmd_t;

  // True when a byte carries the frame-start tag in bits [7:5].
  function automatic logic is_header(input logic [BYTE_W-1:0] b);
    return (b[7:5] == SYNC_TAG);
  endfunction

endpackage

// File: rtl/reg_file_loader.sv
// reg_file_loader: turns 5-byte frames from the serial byte receiver into
// single-cycle register-file writes.
//   Frame: header {SYNC_TAG, index[4:0]}, then 4 data bytes, little-endian.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rx_data/valid   incoming byte stream; rx_ready = loader can accept
//   wr_en           one-cycle register-file write strobe (never for x0)
//   wr_reg_index    register index of the last committed write
//   wr_reg_data     data of the last committed write
//   busy            frame in progress (state != IDLE)
//   frame_err       one-cycle pulse on bad header or inter-byte timeout
//   wr_count        committed writes, wraps 255 -> 0
module reg_file_loader
  import reg_file_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BYTE_W-1:0]          rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       wr_en,
  output logic [REG_INDEX_WIDTH-1:0] wr_reg_index,
  output logic [REGISTER_WIDTH-1:0]  wr_reg_data,
  output logic                       busy,
  output logic                       frame_err,
  output logic [WR_COUNT_W-1:0]      wr_count
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SHIFT_W = REGISTER_WIDTH - BYTE_W;

  state_e                     r_state;
  state_e                     w_state_nxt;
  logic                       r_rx_ready;
  logic                       r_busy;
  logic                       r_frame_err;
  logic                       r_wr_en;
  logic [WR_COUNT_W-1:0]      r_wr_count;
  logic [REG_INDEX_WIDTH-1:0] r_index;
  logic [BYTE_CNT_W-1:0]      r_byte_cnt;
  logic [SHIFT_W-1:0]         r_shift;
  logic [TO_W-1:0]            r_to_cnt;
  wr_cmd_t                    r_cmd;

  logic w_accept;
  logic w_timeout;
  logic w_last_byte;
  logic w_load_hdr;
  logic w_shift;
  logic w_commit;
  logic w_frame_err_nxt;

  assign w_accept    = rx_valid & r_rx_ready;
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_last_byte = (r_byte_cnt == BYTE_CNT_W'(DATA_BYTES - 1));

  // Next-state and per-cycle action decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_hdr      = 1'b0;
    w_shift         = 1'b0;
    w_commit        = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_header(rx_data)) begin
            w_load_hdr  = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_shift = 1'b1;
          if (w_last_byte) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_WRITE;
          end
        end else if (w_timeout) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered status outputs, decoded from next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rx_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_ready  <= (w_state_nxt != ST_WRITE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_frame_err <= w_frame_err_nxt;
      // x0 is hardwired zero: the frame completes but nothing is written.
      r_wr_en     <= w_commit & (r_index != '0);
    end
  end

  // Frame assembly: header index and the first three data lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index    <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      if (w_load_hdr) begin
        r_index    <= rx_data[REG_INDEX_WIDTH-1:0];
        r_byte_cnt <= '0;
      end else if (w_shift) begin
        r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        case (r_byte_cnt)
          2'd0:    r_shift[7:0]   <= rx_data;
          2'd1:    r_shift[15:8]  <= rx_data;
          2'd2:    r_shift[23:16] <= rx_data;
          default: ;
        endcase
      end
    end
  end

  // Committed write payload; holds between frames, only wr_en pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd      <= '0;
      r_wr_count <= '0;
    end else if (w_commit && (r_index != '0)) begin
      r_cmd.index <= r_index;
      r_cmd.data  <= {rx_data, r_shift};
      r_wr_count  <= r_wr_count + WR_COUNT_W'(1);
    end
  end

  // Inter-byte idle counter, only meaningful while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if ((r_state != ST_DATA) || w_accept) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign rx_ready     = r_rx_ready;
  assign busy         = r_busy;
  assign frame_err    = r_frame_err;
  assign wr_en        = r_wr_en;
  assign wr_count     = r_wr_count;
  assign wr_reg_index = r_cmd.index;
  assign wr_reg_data  = r_cmd.data;

endmodule

// File: tb/tb_reg_file_loader.sv
// Directed bench for reg_file_loader: table of frames plus hand sequences for
// latency, timeout, continuous rx_valid and mid-frame reset.
module tb_reg_file_loader;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [4:0]  wr_reg_index;
  logic [31:0] wr_reg_data;
  logic        busy;
  logic        frame_err;
  logic [7:0]  wr_count;

  reg_file_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_reg_index(wr_reg_index),
    .wr_reg_data(wr_reg_data), .busy(busy), .frame_err(frame_err),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Monitor: pulse counters and last observed write, sampled mid-cycle.
  int          wr_pulses = 0;
  int          err_pulses = 0;
  int          stalls = 0;
  logic [4:0]  mon_idx = '0;
  logic [31:0] mon_data = '0;

  always begin
    @(negedge clk);
    #1;
    if (wr_en === 1'b1) begin
      wr_pulses++;
      mon_idx  = wr_reg_index;
      mon_data = wr_reg_data;
    end
    if (frame_err === 1'b1) err_pulses++;
    if (rx_valid === 1'b1 && rx_ready !== 1'b1) stalls++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present a byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("send_byte_accept", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [39:0] f);
    logic [39:0] v;
    v = f;
    for (int i = 0; i < 5; i++) send_byte(v[39-8*i -: 8]);
  endtask

  task automatic go_idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          nb;
    logic [39:0] by;
    int          exp_wr;
    int          exp_err;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w0, e0, s0;
    logic [39:0] bv;
    logic        seen;

    rst = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #2 rst = 1'b1;
    #10;
    chk("rst_wr_en",     32'(wr_en),        32'd0);
    chk("rst_index",     32'(wr_reg_index), 32'd0);
    chk("rst_data",      wr_reg_data,       32'd0);
    chk("rst_frame_err", 32'(frame_err),    32'd0);
    chk("rst_wr_count",  32'(wr_count),     32'd0);
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_rx_ready",  32'(rx_ready),     32'd1);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{5, 40'hA378563412, 1, 0, 5'd3,  32'h12345678, 8'd1};
    vecs[1] = '{1, 40'h4300000000, 0, 1, 5'd0,  32'h0,        8'd1};
    vecs[2] = '{5, 40'hA101000000, 1, 0, 5'd1,  32'h00000001, 8'd2};
    vecs[3] = '{5, 40'hA0FFFFFFFF, 0, 0, 5'd0,  32'h0,        8'd2};
    vecs[4] = '{5, 40'hBFEFBEADDE, 1, 0, 5'd31, 32'hDEADBEEF, 8'd3};
    vecs[5] = '{1, 40'h1F00000000, 0, 1, 5'd0,  32'h0,        8'd3};
    vecs[6] = '{1, 40'hE200000000, 0, 1, 5'd0,  32'h0,        8'd3};
    vecs[7] = '{5, 40'hA2A0FF0055, 1, 0, 5'd2,  32'h5500FFA0, 8'd4};

    for (int v = 0; v < 8; v++) begin
      w0 = wr_pulses; e0 = err_pulses;
      bv = vecs[v].by;
      for (int i = 0; i < vecs[v].nb; i++) send_byte(bv[39-8*i -: 8]);
      go_idle();
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_wr_pulses", v),  32'(wr_pulses - w0),  32'(vecs[v].exp_wr));
      chk($sformatf("v%0d_err_pulses", v), 32'(err_pulses - e0), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_wr_count", v),   32'(wr_count),        32'(vecs[v].cnt));
      chk($sformatf("v%0d_busy", v),       32'(busy),            32'd0);
      if (vecs[v].exp_wr != 0) begin
        chk($sformatf("v%0d_index", v), 32'(mon_idx), 32'(vecs[v].idx));
        chk($sformatf("v%0d_data", v),  mon_data,     vecs[v].data);
      end
    end

    // Latency: wr_en exactly the cycle after the last byte, then ready again.
    send_frame(40'hA701020304);
    go_idle();
    chk("lat_wr_en",    32'(wr_en),        32'd1);
    chk("lat_rx_ready", 32'(rx_ready),     32'd0);
    chk("lat_busy",     32'(busy),         32'd1);
    chk("lat_index",    32'(wr_reg_index), 32'd7);
    chk("lat_data",     wr_reg_data,       32'h04030201);
    chk("lat_count",    32'(wr_count),     32'd5);
    @(negedge clk);
    chk("lat_wr_en_off", 32'(wr_en),    32'd0);
    chk("lat_ready_on",  32'(rx_ready), 32'd1);
    chk("lat_busy_off",  32'(busy),     32'd0);
    chk("lat_data_hold", wr_reg_data,   32'h04030201);

    // Inter-byte timeout discards the partial frame.
    e0 = err_pulses; w0 = wr_pulses;
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    go_idle();
    repeat (10) @(negedge clk);
    chk("to_busy_before", 32'(busy),             32'd1);
    chk("to_no_err_yet",  32'(err_pulses - e0),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (err_pulses != e0) seen = 1'b1;
    end
    chk("to_err_pulse", 32'(err_pulses - e0), 32'd1);
    chk("to_busy_drop", 32'(busy),            32'd0);
    send_frame(40'hA5DDCCBBAA);
    go_idle();
    repeat (3) @(negedge clk);
    chk("to_next_wr",    32'(wr_pulses - w0), 32'd1);
    chk("to_next_index", 32'(mon_idx),        32'd5);
    chk("to_next_data",  mon_data,            32'hAABBCCDD);

    // rx_valid held high across two frames: one stall cycle, both written.
    do_reset();
    w0 = wr_pulses; s0 = stalls;
    send_frame(40'hA811111111);
    send_frame(40'hA922222222);
    go_idle();
    repeat (3) @(negedge clk);
    chk("cont_wr_pulses", 32'(wr_pulses - w0), 32'd2);
    chk("cont_stalls",    32'(stalls - s0),    32'd1);
    chk("cont_wr_count",  32'(wr_count),       32'd2);
    chk("cont_index",     32'(mon_idx),        32'd9);
    chk("cont_data",      mon_data,            32'h22222222);

    // Reset mid-frame: outputs return to reset values immediately.
    w0 = wr_pulses;
    send_byte(8'hAA); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_wr_en",    32'(wr_en),        32'd0);
    chk("mrst_busy",     32'(busy),         32'd0);
    chk("mrst_rx_ready", 32'(rx_ready),     32'd1);
    chk("mrst_count",    32'(wr_count),     32'd0);
    chk("mrst_index",    32'(wr_reg_index), 32'd0);
    chk("mrst_data",     wr_reg_data,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_no_wr", 32'(wr_pulses - w0), 32'd0);
    send_frame(40'hAA44332211);
    go_idle();
    repeat (3) @(negedge clk);
    chk("mrst_fresh_wr",    32'(wr_pulses - w0), 32'd1);
    chk("mrst_fresh_index", 32'(mon_idx),        32'd10);
    chk("mrst_fresh_data",  mon_data,            32'h11223344);
    chk("mrst_fresh_count", 32'(wr_count),       32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
